// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings and FSM state type.
package alu_mc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SLT = 3'b100,
    OP_NOR = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between an ALU client (master) and alu_mc (slave).
interface alu_mc_if #(parameter int WIDTH = 16);
  import alu_mc_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Request side: src1/src2/op are sampled when in_valid && in_ready.
  // Response side: result and flags stay stable while out_valid && !out_ready.
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     src1;
  logic [WIDTH-1:0]     src2;
  logic [OP_W-1:0]      op;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 zero;
  logic                 overflow;
  logic                 carry;

  modport master (
    output in_valid, src1, src2, op, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry
  );

  modport slave (
    input  in_valid, src1, src2, op, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry
  );

endinterface

// File: rtl/alu_mc_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out and signed overflow.
module alu_mc_addsub #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  // Subtraction is a + ~b + 1, so cout=1 means no borrow.
  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign ovf         = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_mc_if.slave bus,
  output state_e state_dbg
);

  localparam int CW = $clog2(WIDTH);

  state_e           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, ovf_q, carry_q;

  logic [WIDTH-1:0] as_a, as_b, as_sum;
  logic             as_sub, as_cout, as_ovf;
  logic [WIDTH-1:0] alu_res, hi_nx, lo_nx;
  logic             alu_ovf, alu_carry;
  logic             accept, last_step, is_mul;

  assign accept    = bus.in_valid && (state == ST_IDLE);
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign is_mul    = (op_e'(bus.op) == OP_MUL);

  // The shared adder serves the incoming operands in IDLE and the
  // partial-product accumulation while multiplying.
  always_comb begin
    as_a   = bus.src1;
    as_b   = bus.src2;
    as_sub = (op_e'(bus.op) == OP_SUB) || (op_e'(bus.op) == OP_SLT);
    if (state == ST_MUL) begin
      as_a   = hi;
      as_b   = lo[0] ? mcand : '0;
      as_sub = 1'b0;
    end
  end

  alu_mc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  assign hi_nx = {as_cout, as_sum[WIDTH-1:1]};
  assign lo_nx = {as_sum[0], lo[WIDTH-1:1]};

  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    case (op_e'(bus.op))
      OP_AND: alu_res = bus.src1 & bus.src2;
      OP_OR:  alu_res = bus.src1 | bus.src2;
      OP_NOR: alu_res = ~(bus.src1 | bus.src2);
      OP_ADD, OP_SUB: begin
        alu_res   = as_sum;
        alu_ovf   = as_ovf;
        alu_carry = as_cout;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.in_valid) state_nx = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (last_step)    state_nx = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          cnt   <= '0;
          mcand <= bus.src1;
          hi    <= '0;
          lo    <= bus.src2;
          if (!is_mul) begin
            res_q   <= alu_res;
            zero_q  <= ~|alu_res;
            ovf_q   <= alu_ovf;
            carry_q <= alu_carry;
          end
        end
        ST_MUL: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            res_q   <= lo_nx;
            zero_q  <= ~|lo_nx;
            ovf_q   <= |hi_nx;
            carry_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry     = carry_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=16 with hand-computed expectations.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 16;

  logic   clk;
  logic   rst_n;
  state_e state_dbg;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one request and returns the number of rising edges, counting
  // the accepting edge, until out_valid is seen.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.src1     = a;
    bus.src2     = b;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e_res, input logic e_z,
                       input logic e_o, input logic e_c, input int e_lat);
    int lat;
    logic [W-1:0] e;
    exp_q.push_back(e_res);
    issue(op, a, b, lat);
    e = exp_q.pop_front();
    check({tag, ".lat"},    64'(lat), 64'(e_lat));
    check({tag, ".result"}, 64'(bus.result), 64'(e));
    check({tag, ".flags"},  64'({bus.zero, bus.overflow, bus.carry}), 64'({e_z, e_o, e_c}));
    pop();
    check({tag, ".released"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
  endtask

  initial begin
    int lat;
    int seen_valid;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.src1      = '0;
    bus.src2      = '0;
    rst_n         = 1'b0;
    repeat (3) tick();

    check("reset.outputs", 64'({bus.out_valid, bus.result, bus.zero, bus.overflow, bus.carry}),
          64'({1'b0, 16'h0000, 1'b1, 1'b0, 1'b0}));
    rst_n = 1'b1;
    tick();
    check("reset.in_ready", 64'(bus.in_ready), 64'(1));
    check("reset.state", 64'(state_dbg), 64'(ST_IDLE));

    //      tag        op       src1      src2      result    z     o     c     lat
    do_op("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1);
    do_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1);
    do_op("sub_eq",   OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1);
    do_op("sub_brw",  OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1);
    do_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1);
    do_op("slt_neg",  OP_SLT, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
    do_op("slt_pos",  OP_SLT, 16'h7FFF, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
    do_op("and",      OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1);
    do_op("or",       OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0, 1'b0, 1);
    do_op("nor",      OP_NOR, 16'hF0F0, 16'h3C3C, 16'h0303, 1'b0, 1'b0, 1'b0, 1);
    do_op("nor_zero", OP_NOR, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
    do_op("rsv",      OP_RSV, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
    do_op("mul_small", OP_MUL, 16'd300, 16'd7,    16'h0834, 1'b0, 1'b0, 1'b0, 17);
    do_op("mul_hi",    OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 17);
    do_op("mul_max",   OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 17);

    // Back-pressure: result held for 5 cycles, competing request ignored.
    issue(OP_ADD, 16'h0001, 16'h0002, lat);
    check("bp.lat", 64'(lat), 64'(1));
    bus.in_valid = 1'b1;
    bus.op       = OP_AND;
    bus.src1     = 16'hFFFF;
    bus.src2     = 16'h00FF;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.hold%0d", i),
            64'({bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.overflow, bus.carry}),
            64'({1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0}));
      tick();
    end
    bus.in_valid = 1'b0;
    pop();
    check("bp.after_pop", 64'({bus.out_valid, bus.in_ready, bus.result}),
          64'({1'b0, 1'b1, 16'h0003}));
    tick();
    check("bp.single_result", 64'({bus.out_valid, state_dbg}), 64'({1'b0, ST_IDLE}));

    // Reset in the middle of a multiply discards it.
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.src1     = 16'd300;
    bus.src2     = 16'd7;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("rst_mul.state_before", 64'(state_dbg), 64'(ST_MUL));
    rst_n = 1'b0;
    #1;
    check("rst_mul.immediate", 64'({bus.out_valid, state_dbg, bus.result, bus.zero}),
          64'({1'b0, ST_IDLE, 16'h0000, 1'b1}));
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mul.in_ready", 64'(bus.in_ready), 64'(1));
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen_valid++;
      tick();
    end
    check("rst_mul.no_stale", 64'(seen_valid), 64'(0));

    do_op("post_rst", OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port src1  input  WIDTH  first operand.
REQ-007 SHALL have port src2  input  WIDTH  second operand.
REQ-008 SHALL have port op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 reserved.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have ports zero, overflow, carry  output  1 each  status flags.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept an operation when in_valid&in_ready, registering src1, src2, op in that cycle.
REQ-015 For non-MUL ops, SHALL enter DONE the cycle after accept with out_valid=1 (latency 1).
REQ-016 For MUL, SHALL enter MUL, perform unsigned shift-add over exactly WIDTH cycles (counter 0..WIDTH-1), then enter DONE (latency WIDTH+1).
REQ-017 MUL result SHALL be low WIDTH bits of the product; overflow=1 iff upper WIDTH bits nonzero; carry=0.
REQ-018 ADD/SUB SHALL be WIDTH-bit two's complement; overflow = signed overflow; carry = carry-out (SUB: 1 means no borrow, src1>=src2 unsigned).
REQ-019 SLT SHALL output 1 in bit 0 (others 0) iff src1<src2 signed, computed as sign(src1-src2) XOR overflow; overflow and carry SHALL read 0.
REQ-020 AND/OR/NOR SHALL be bitwise; overflow=carry=0.
REQ-021 Reserved opcode SHALL give result 0, zero=1, overflow=carry=0, latency 1.
REQ-022 zero SHALL be 1 iff result==0, for every op.
REQ-023 In DONE, result and flags SHALL be held stable until out_valid&out_ready; then the FSM SHALL return to IDLE the next cycle (no same-cycle re-accept).
REQ-024 in_valid while in_ready=0 SHALL be ignored with no state effect.
REQ-025 Outside DONE, out_valid SHALL be 0; result/flags hold last value.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, in_ready=1 (after release), out_valid=0, result=0, zero=1, overflow=0, carry=0, counter=0.
REQ-027 Reset during MUL or DONE SHALL discard the operation; no result is presented after release.

Structure
REQ-028 Opcode encodings and the FSM state type SHALL live in a shared package alu_mc_pkg.
REQ-029 A combinational sub-module alu_mc_addsub (WIDTH-param adder/subtractor with carry-out and overflow) SHALL serve ADD/SUB/SLT and MUL accumulation.

Verification (WIDTH=16)
REQ-030 ADD 0x7FFF+0x0001 -> result 0x8000, overflow=1, carry=0, zero=0, out_valid 1 cycle after accept.
REQ-031 SUB 0x0005-0x0005 -> result 0x0000, zero=1, carry=1, overflow=0.
REQ-032 SLT 0x8000,0x0001 -> result 0x0001; SLT 0x7FFF,0x8000 -> result 0x0000.
REQ-033 MUL 300*7 -> 0x0834, overflow=0 after exactly 17 cycles; MUL 0x0100*0x0100 -> 0x0000, zero=1, overflow=1.
REQ-034 out_ready held low 5 cycles in DONE -> result/flags stable, in_ready=0, concurrent in_valid ignored; one result delivered.
REQ-035 rst_n asserted on cycle 5 of MUL -> out_valid=0 immediately, in_ready=1 after release, no stale result emitted.
